// File: rtl/dac_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : dac_burst_seq
// Description : Divides clk into a DAC sample clock and pulls one upstream
//               sample per DAC period, in bursts or continuously.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_burst_seq #(
    parameter int                    DOUT_WIDTH  = 14,
    parameter int                    DIV_WIDTH   = 8,
    parameter int                    BURST_WIDTH = 16,
    parameter logic [DOUT_WIDTH-1:0] IDLE_CODE   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DOUT_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   dac_clk,
    output logic [DOUT_WIDTH-1:0]  dout,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0]   c_div_min = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0]   c_div_one = DIV_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] c_cnt_one = BURST_WIDTH'(1);

    state_t                  r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0]    r_div, w_div_nxt;
    logic [DIV_WIDTH-1:0]    r_phase, w_phase_nxt;
    logic [BURST_WIDTH-1:0]  r_len, w_len_nxt;
    logic [BURST_WIDTH-1:0]  r_count, w_count_nxt;
    logic                    r_stop_pend, w_stop_pend_nxt;
    logic                    r_dac_clk, w_dac_clk_nxt;
    logic [DOUT_WIDTH-1:0]   r_dout, w_dout_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_underrun, w_underrun_nxt;

    logic                    w_last;
    logic                    w_rise;
    logic                    w_slot;
    logic [BURST_WIDTH-1:0]  w_count_inc;

    assign w_last      = (r_phase == (r_div - c_div_one));
    assign w_rise      = (r_phase == ((r_div >> 1) - c_div_one));
    assign w_slot      = (r_state == S_RUN) && w_last;
    assign w_count_inc = r_count + c_cnt_one;

    assign s_ready  = !rst && w_slot && !r_stop_pend;
    assign dac_clk  = r_dac_clk;
    assign dout     = r_dout;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign underrun = r_underrun;

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_phase_nxt     = r_phase;
        w_len_nxt       = r_len;
        w_count_nxt     = r_count;
        w_stop_pend_nxt = r_stop_pend;
        w_dac_clk_nxt   = r_dac_clk;
        w_dout_nxt      = r_dout;
        w_done_nxt      = 1'b0;
        w_underrun_nxt  = r_underrun;

        case (r_state)
            S_IDLE: begin
                w_phase_nxt   = '0;
                w_count_nxt   = '0;
                w_dac_clk_nxt = 1'b0;
                w_dout_nxt    = IDLE_CODE;
                if (start && !stop) begin
                    w_div_nxt       = (div < c_div_min) ? c_div_min : div;
                    w_len_nxt       = burst_len;
                    w_underrun_nxt  = 1'b0;
                    w_stop_pend_nxt = 1'b0;
                    w_state_nxt     = S_RUN;
                end
            end
            S_RUN, S_FLUSH: begin
                w_phase_nxt = w_last ? '0 : (r_phase + c_div_one);
                if (w_rise) w_dac_clk_nxt = 1'b1;
                if (w_last) w_dac_clk_nxt = 1'b0;

                // Exit on the falling edge so the DAC never latches a partial period.
                if ((r_state == S_FLUSH && w_last) || (w_slot && r_stop_pend)) begin
                    w_dout_nxt    = IDLE_CODE;
                    w_dac_clk_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_count_nxt   = '0;
                    w_state_nxt   = S_IDLE;
                end else if (r_state == S_RUN) begin
                    if (stop) w_stop_pend_nxt = 1'b1;
                    if (w_slot) begin
                        if (s_valid) w_dout_nxt = s_data;
                        else         w_underrun_nxt = 1'b1;
                        w_count_nxt = w_count_inc;
                        if ((r_len != '0) && (w_count_inc == r_len)) w_state_nxt = S_FLUSH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= c_div_min;
            r_phase     <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_stop_pend <= 1'b0;
            r_dac_clk   <= 1'b0;
            r_dout      <= IDLE_CODE;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_phase     <= w_phase_nxt;
            r_len       <= w_len_nxt;
            r_count     <= w_count_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_dac_clk   <= w_dac_clk_nxt;
            r_dout      <= w_dout_nxt;
            r_done      <= w_done_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

endmodule
`default_nettype wire
